// File: rtl/sample_playback.sv
// Purpose : plays a sample clip from ROM into an audio-out controller at a fixed
//           sample rate. Each sample is fetched, scaled and written once.
// Latency : a fetch takes ROM_LAT cycles. The first write strobe comes RATE_DIV
//           cycles after start is accepted, and later strobes follow every RATE_DIV cycles.
// Backpr. : while audio_out_allowed=0 the WRITE state stalls with no time limit. Any
//           rate tick that lands in FETCH or WRITE sets the sticky underrun flag.
//
// Ports:
//   CLOCK_50                 system clock
//   reset                    synchronous active-high reset (priority over start/stop)
//   start / stop             playback begin pulse / abort pulse (stop wins over start)
//   rom_address, rom_q       external sample ROM (rom_q valid ROM_LAT cycles after address)
//   audio_out_allowed        audio controller has FIFO space
//   write_audio_out          one-cycle write strobe (combinational, qualified by allowed)
//   left/right_channel_...   sample zero-extended to 32 bits, << SHIFT, truncated
//   playing, done, underrun  busy / end-of-clip pulse (with final strobe) / sticky flag
//
// Build option: define SAMPLE_PLAYBACK_LOOP_EN to make the clip loop continuously
// instead of stopping after the write at LAST_ADDR.

module sample_playback #(
    parameter int ADDR_W    = 16,
    parameter int SAMPLE_W  = 19,
    parameter int LAST_ADDR = 50160,
    parameter int RATE_DIV  = 10000,
    parameter int SHIFT     = 14,
    parameter int ROM_LAT   = 2
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    output logic [ADDR_W-1:0]   rom_address,
    input  logic [SAMPLE_W-1:0] rom_q,
    input  logic                audio_out_allowed,
    output logic                write_audio_out,
    output logic [31:0]         left_channel_audio_out,
    output logic [31:0]         right_channel_audio_out,
    output logic                playing,
    output logic                done,
    output logic                underrun
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_FETCH     = 2'd1;
    localparam logic [1:0] S_WAIT_TICK = 2'd2;
    localparam logic [1:0] S_WRITE     = 2'd3;

    localparam int                CNT_W      = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(RATE_DIV - 1);
    localparam logic [1:0]        FETCH_LAST = 2'(ROM_LAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(LAST_ADDR);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        state_q,     state_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [CNT_W-1:0]  rate_cnt_q,  rate_cnt_d;
    logic [1:0]        fetch_cnt_q, fetch_cnt_d;
    logic [31:0]       chan_q,      chan_d;
    logic              playing_q,   playing_d;
    logic              underrun_q,  underrun_d;

    // ------------------------------------------------------------------
    // Strobes derived from current state
    // ------------------------------------------------------------------
    logic tick;
    logic wr_fire;
    logic clip_end;
    logic [31:0] sample_scaled;

    // The rate counter only runs while playing. The wrap cycle is the tick.
    assign tick = playing_q && (rate_cnt_q == CNT_MAX);

    // The write strobe is combinational so that it matches audio_out_allowed in the
    // same cycle. Stop and reset suppress it because they abort the pending write at this edge.
    assign wr_fire  = (state_q == S_WRITE) && audio_out_allowed && !stop && !reset;
    assign clip_end = wr_fire && (addr_q == ADDR_LAST);

    // Zero-extend to 32 bits first, then shift. Bits shifted past bit 31 are dropped.
    assign sample_scaled = 32'(rom_q) << SHIFT;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        fetch_cnt_d = fetch_cnt_q;
        chan_d      = chan_q;
        playing_d   = playing_q;
        underrun_d  = underrun_q;
        rate_cnt_d  = rate_cnt_q;

        // The sample period runs freely while playing. It is independent of the
        // FSM, so a stalled write cannot shift later ticks.
        if (playing_q) begin
            if (tick) begin
                rate_cnt_d = '0;
            end else begin
                rate_cnt_d = rate_cnt_q + CNT_W'(1);
            end
        end

        // A period boundary before the previous sample has been fetched and
        // written means a sample slot was missed.
        if (tick && ((state_q == S_FETCH) || (state_q == S_WRITE))) begin
            underrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = '0;
                    rate_cnt_d  = '0;
                    fetch_cnt_d = '0;
                    playing_d   = 1'b1;
                    underrun_d  = 1'b0;
                    state_d     = S_FETCH;
                end
            end

            S_FETCH: begin
                // The ROM needs ROM_LAT cycles after an address change. The data is
                // captured on the edge that ends the last of those cycles.
                if (fetch_cnt_q == FETCH_LAST) begin
                    chan_d  = sample_scaled;
                    state_d = S_WAIT_TICK;
                end else begin
                    fetch_cnt_d = fetch_cnt_q + 2'd1;
                end
            end

            S_WAIT_TICK: begin
                if (tick) begin
                    state_d = S_WRITE;
                end
            end

            S_WRITE: begin
                if (wr_fire) begin
                    if (addr_q != ADDR_LAST) begin
                        addr_d      = addr_q + ADDR_W'(1);
                        fetch_cnt_d = '0;
                        state_d     = S_FETCH;
                    end else begin
`ifdef SAMPLE_PLAYBACK_LOOP_EN
                        // Wrap around and keep playing. The rate counter keeps running,
                        // so the loop seam uses the same sample period.
                        addr_d      = '0;
                        fetch_cnt_d = '0;
                        state_d     = S_FETCH;
`else
                        addr_d      = '0;
                        rate_cnt_d  = '0;
                        playing_d   = 1'b0;
                        state_d     = S_IDLE;
`endif
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything above, including a start or a pending write
        // in this cycle. The channel outputs and underrun keep their values.
        if (stop) begin
            state_d     = S_IDLE;
            addr_d      = '0;
            rate_cnt_d  = '0;
            fetch_cnt_d = '0;
            playing_d   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rate_cnt_q  <= '0;
            fetch_cnt_q <= '0;
            chan_q      <= '0;
            playing_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rate_cnt_q  <= rate_cnt_d;
            fetch_cnt_q <= fetch_cnt_d;
            chan_q      <= chan_d;
            playing_q   <= playing_d;
            underrun_q  <= underrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rom_address             = addr_q;
    assign write_audio_out         = wr_fire;
    assign done                    = clip_end;
    assign left_channel_audio_out  = chan_q;
    assign right_channel_audio_out = chan_q;
    assign playing                 = playing_q;
    assign underrun                = underrun_q;

endmodule

// File: tb/tb_sample_playback.sv
// Purpose : directed self-checking bench for sample_playback with a ROM model where word n = n+1.
// Latency : the ROM model registers the address once, so rom_q is valid in the 2nd cycle after a change.
// Backpr. : the bench drives audio_out_allowed directly to create write stalls.

module tb_sample_playback;

    localparam int ADDR_W    = 16;
    localparam int SAMPLE_W  = 19;
    localparam int LAST_ADDR = 3;
    localparam int RATE_DIV  = 8;
    localparam int SHIFT     = 14;
    localparam int ROM_LAT   = 2;

    typedef struct packed {
        logic [31:0] data;
        logic        done;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic                stop = 1'b0;
    logic                allowed = 1'b1;
    logic                rom_ones = 1'b0;
    logic [ADDR_W-1:0]   rom_address;
    logic [SAMPLE_W-1:0] rom_q;
    logic                write_audio_out;
    logic [31:0]         left_out;
    logic [31:0]         right_out;
    logic                playing;
    logic                done;
    logic                underrun;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   c0 = 0;
    int   strobe_cnt = 0;
    int   done_cnt = 0;
    int   base = 0;
    int   base_done = 0;
    int   strobe_cyc[$];
    exp_t sb[$];
    exp_t e;

    sample_playback #(
        .ADDR_W    (ADDR_W),
        .SAMPLE_W  (SAMPLE_W),
        .LAST_ADDR (LAST_ADDR),
        .RATE_DIV  (RATE_DIV),
        .SHIFT     (SHIFT),
        .ROM_LAT   (ROM_LAT)
    ) dut (
        .CLOCK_50                (clk),
        .reset                   (reset),
        .start                   (start),
        .stop                    (stop),
        .rom_address             (rom_address),
        .rom_q                   (rom_q),
        .audio_out_allowed       (allowed),
        .write_audio_out         (write_audio_out),
        .left_channel_audio_out  (left_out),
        .right_channel_audio_out (right_out),
        .playing                 (playing),
        .done                    (done),
        .underrun                (underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM: word n holds n+1, or all ones when rom_ones is set.
    always @(posedge clk) begin
        if (rom_ones) rom_q <= {SAMPLE_W{1'b1}};
        else          rom_q <= SAMPLE_W'(rom_address) + SAMPLE_W'(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Output monitor: each write strobe pops one scoreboard entry.
    always @(negedge clk) begin
        if (!reset) begin
            if (done === 1'b1) begin
                done_cnt++;
                check("done_with_write", {31'b0, write_audio_out}, 32'd1);
            end
            if (write_audio_out === 1'b1) begin
                strobe_cnt++;
                strobe_cyc.push_back(cyc);
                check("strobe_expected", {31'b0, (sb.size() > 0)}, 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("left_data", left_out, e.data);
                    check("right_data", right_out, e.data);
                    check("done_flag", {31'b0, done}, {31'b0, e.done});
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        c0 = cyc;
        start = 1'b0;
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input logic dn);
        exp_t x;
        x.data = d;
        x.done = dn;
        sb.push_back(x);
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int n = 0;
        while (strobe_cnt < target && n < budget) begin
            step();
            n++;
        end
        check("strobe_wait", {31'b0, (strobe_cnt >= target)}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        step(3);
        check("rst_addr", 32'(rom_address), 32'd0);
        check("rst_left", left_out, 32'd0);
        check("rst_right", right_out, 32'd0);
        check("rst_write", {31'b0, write_audio_out}, 32'd0);
        check("rst_playing", {31'b0, playing}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_underrun", {31'b0, underrun}, 32'd0);
        reset = 1'b0;
        step(2);

        // ---------------- full clip at the sample rate ----------------
        allowed = 1'b1;
        push(32'h0000_4000, 1'b0);
        push(32'h0000_8000, 1'b0);
        push(32'h0000_C000, 1'b0);
        push(32'h0001_0000, 1'b1);
`ifdef SAMPLE_PLAYBACK_LOOP_EN
        push(32'h0000_4000, 1'b0);
        push(32'h0000_8000, 1'b0);
        push(32'h0000_C000, 1'b0);
        push(32'h0001_0000, 1'b1);
`endif
        start_pulse();
        check("start_playing", {31'b0, playing}, 32'd1);
        wait_strobes(4, 100);
        check("first_strobe_latency", 32'(strobe_cyc[0] - c0), 32'd8);
        for (int i = 1; i < 4; i++) begin
            check("strobe_spacing", 32'(strobe_cyc[i] - strobe_cyc[i-1]), 32'd8);
        end
        check("addr_after_clip", 32'(rom_address), 32'd0);
`ifdef SAMPLE_PLAYBACK_LOOP_EN
        check("loop_playing", {31'b0, playing}, 32'd1);
        wait_strobes(8, 100);
        check("loop_done_count", 32'(done_cnt), 32'd2);
        check("loop_spacing", 32'(strobe_cyc[4] - strobe_cyc[3]), 32'd8);
        stop_pulse();
        check("loop_stopped", {31'b0, playing}, 32'd0);
`else
        check("end_playing", {31'b0, playing}, 32'd0);
        check("end_done_count", 32'(done_cnt), 32'd1);
        step(30);
        check("no_strobe_after_end", 32'(strobe_cnt), 32'd4);
`endif
        check("sb_empty_a", 32'(sb.size()), 32'd0);
        step(3);

        // ---------------- write stall -> underrun ----------------
        allowed = 1'b0;
        base = strobe_cnt;
        push(32'h0000_4000, 1'b0);
        start_pulse();
        step(28);
        check("stall_no_strobe", 32'(strobe_cnt), 32'(base));
        check("stall_underrun", {31'b0, underrun}, 32'd1);
        check("stall_playing", {31'b0, playing}, 32'd1);
        allowed = 1'b1;
        step();
        allowed = 1'b0;
        check("stall_single_strobe", 32'(strobe_cnt), 32'(base + 1));
        stop_pulse();
        check("stall_stopped", {31'b0, playing}, 32'd0);
        check("underrun_sticky", {31'b0, underrun}, 32'd1);
        step(10);
        check("stall_no_extra", 32'(strobe_cnt), 32'(base + 1));

        // ---------------- stop against a pending write ----------------
        allowed = 1'b0;
        base = strobe_cnt;
        base_done = done_cnt;
        start_pulse();
        check("start_clears_underrun", {31'b0, underrun}, 32'd0);
        step(10);
        allowed = 1'b1;
        stop = 1'b1;
        #2;
        check("stop_write_blocked", {31'b0, write_audio_out}, 32'd0);
        check("stop_done_low", {31'b0, done}, 32'd0);
        step();
        stop = 1'b0;
        check("stop_playing", {31'b0, playing}, 32'd0);
        check("stop_addr", 32'(rom_address), 32'd0);
        check("stop_write_after", {31'b0, write_audio_out}, 32'd0);
        step(12);
        check("stop_no_strobe", 32'(strobe_cnt), 32'(base));
        check("stop_no_done", 32'(done_cnt), 32'(base_done));

        // ---------------- reset during a write stall ----------------
        allowed = 1'b0;
        start_pulse();
        step(20);
        check("pre_reset_underrun", {31'b0, underrun}, 32'd1);
        check("pre_reset_left", left_out, 32'h0000_4000);
        reset = 1'b1;
        step();
        check("mid_rst_addr", 32'(rom_address), 32'd0);
        check("mid_rst_left", left_out, 32'd0);
        check("mid_rst_right", right_out, 32'd0);
        check("mid_rst_write", {31'b0, write_audio_out}, 32'd0);
        check("mid_rst_playing", {31'b0, playing}, 32'd0);
        check("mid_rst_done", {31'b0, done}, 32'd0);
        check("mid_rst_underrun", {31'b0, underrun}, 32'd0);
        reset = 1'b0;
        allowed = 1'b1;
        step();
        base = strobe_cnt;
        push(32'h0000_4000, 1'b0);
        start_pulse();
        wait_strobes(base + 1, 40);
        check("replay_latency", 32'(strobe_cyc[strobe_cyc.size()-1] - c0), 32'd8);
        stop_pulse();

        // ---------------- full-scale sample truncation ----------------
        rom_ones = 1'b1;
        step(2);
        base = strobe_cnt;
        push(32'hFFFF_C000, 1'b0);
        start_pulse();
        wait_strobes(base + 1, 40);
        stop_pulse();
        rom_ones = 1'b0;
        step(2);

        check("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sample_playback.md
SAMPLE_PLAYBACK -- requirements
Module: sample_playback

Interface
REQ-001 SHALL have parameter ADDR_W, default 16; sample ROM address width.
REQ-002 SHALL have parameter SAMPLE_W, default 19; ROM word width (unsigned).
REQ-003 SHALL have parameter LAST_ADDR, default 50160; final ROM address played.
REQ-004 SHALL have parameter RATE_DIV, default 10000; CLOCK_50 cycles per sample period, min 8.
REQ-005 SHALL have parameter SHIFT, default 14; left shift applied to samples.
REQ-006 SHALL have parameter ROM_LAT, default 2; cycles from rom_address change to valid rom_q, range 1-3.
REQ-007 SHALL have ports: CLOCK_50 in 1 system clock; reset in 1 synchronous active-high reset.
REQ-008 SHALL have ports: start in 1 begin playback pulse; stop in 1 abort pulse.
REQ-009 SHALL have ports: rom_address out ADDR_W ROM address; rom_q in SAMPLE_W ROM data.
REQ-010 SHALL have ports: audio_out_allowed in 1 controller has FIFO space; write_audio_out out 1 one-cycle write strobe.
REQ-011 SHALL have ports: left_channel_audio_out, right_channel_audio_out out 32 scaled sample.
REQ-012 SHALL have ports: playing out 1 busy; done out 1 end-of-clip pulse; underrun out 1 sticky missed-period flag.

Function
REQ-013 SHALL implement states IDLE, FETCH, WAIT_TICK, WRITE.
REQ-014 IDLE: start=1 SHALL load rom_address=0, clear rate counter, set playing=1, go to FETCH; start ignored in other states.
REQ-015 FETCH SHALL last exactly ROM_LAT cycles, then capture rom_q into sample register and go to WAIT_TICK.
REQ-016 Rate counter SHALL count 0..RATE_DIV-1 while playing, wrapping; wrap cycle is the tick.
REQ-017 WAIT_TICK: on tick SHALL go to WRITE; first tick SHALL occur RATE_DIV cycles after start accepted.
REQ-018 WRITE: write_audio_out SHALL be 1 exactly in the cycle audio_out_allowed=1, else 0; stall indefinitely while audio_out_allowed=0.
REQ-019 Both channel outputs SHALL equal sample zero-extended to 32 bits shifted left SHIFT, truncated to 32 bits; updated when sample is captured, held otherwise.
REQ-020 After a write with rom_address<LAST_ADDR SHALL increment rom_address and go to FETCH.
REQ-021 After a write with rom_address==LAST_ADDR SHALL behave per REQ-028/REQ-029.
REQ-022 A tick arriving while state is FETCH or WRITE SHALL set underrun=1; cleared only by reset or start.
REQ-023 stop=1 SHALL, next edge, force IDLE, playing=0, write_audio_out=0, rom_address=0; stop wins over start and over a pending write in the same cycle.
REQ-024 done SHALL pulse 1 for one cycle only on clip completion, never on stop.

Reset
REQ-025 reset=1 SHALL, at next CLOCK_50 edge, force IDLE from any state, including mid-WRITE stall.
REQ-026 Reset values SHALL be rom_address=0, both channel outputs=0, write_audio_out=0, playing=0, done=0, underrun=0, rate counter=0.
REQ-027 reset SHALL take priority over start and stop.

Configuration
REQ-028 With SAMPLE_PLAYBACK_LOOP_EN defined, the write at LAST_ADDR SHALL pulse done, set rom_address=0, go to FETCH, and keep playing=1 (continuous loop).
REQ-029 Without SAMPLE_PLAYBACK_LOOP_EN, the write at LAST_ADDR SHALL pulse done, set playing=0, rom_address=0, go to IDLE.

Verification (RATE_DIV=8, LAST_ADDR=3, ROM_LAT=2, SHIFT=14, ROM word n = n+1)
REQ-030 reset, start, audio_out_allowed=1 -> four write strobes 8 cycles apart, outputs 0x4000, 0x8000, 0xC000, 0x10000; done pulse with 4th write.
REQ-031 Loop off -> after 4th write playing=0, no further strobes; loop on -> 5th write 0x4000, done every 4 writes.
REQ-032 audio_out_allowed=0 for 20 cycles during WRITE -> no strobe during stall, underrun=1, single strobe when allowed returns.
REQ-033 stop asserted same cycle as a pending write -> write_audio_out=0, playing=0 next cycle, done stays 0.
REQ-034 reset during WRITE stall -> all outputs at REQ-026 values next cycle; start then replays from address 0.
REQ-035 rom_q=all ones (0x7FFFF) -> channel outputs 0xFFFFC000 (MSB truncated).
